// File: rtl/kd_tree_pkg.sv
// Shared definitions for the KD-tree node array: word layout, loader states,
// and the expected-readback helper.
package kd_tree_pkg;

    localparam int STORAGE_WIDTH = 22;
    localparam int IDX_LSB       = 0;
    localparam int IDX_W         = 3;
    localparam int MED_LSB       = 11;
    localparam int MED_W         = 11;
    localparam int MAX_IDX       = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Nodes keep only idx and median, so the unused middle bits read back as zero.
    function automatic logic [STORAGE_WIDTH-1:0] expected_readback(
        input logic [STORAGE_WIDTH-1:0] w
    );
        logic [STORAGE_WIDTH-1:0] r;
        r = '0;
        r[MED_LSB +: MED_W] = w[MED_LSB +: MED_W];
        r[IDX_LSB +: IDX_W] = w[IDX_LSB +: IDX_W];
        return r;
    endfunction

endpackage

// File: rtl/kd_node_loader_if.sv
// Configuration stream plus node write/readback bus between the loader and
// the node array.
interface kd_node_loader_if
    import kd_tree_pkg::*;
#(
    parameter int NUM_NODES = 31
) ();

    logic                               in_valid;
    logic                               in_ready;
    logic [STORAGE_WIDTH-1:0]           in_data;
    logic [NUM_NODES-1:0]               node_wen;
    logic [STORAGE_WIDTH-1:0]           node_wdata;
    logic [NUM_NODES*STORAGE_WIDTH-1:0] node_rdata;

    // master: word source and node array; slave: the loader
    modport master (
        output in_valid, in_data, node_rdata,
        input  in_ready, node_wen, node_wdata
    );

    modport slave (
        input  in_valid, in_data, node_rdata,
        output in_ready, node_wen, node_wdata
    );

endinterface

// File: rtl/kd_node_readback_check.sv
// Two-stage pipeline that compares each node's readback against the word
// written to it, keeping a sticky error and the first failing address.
module kd_node_readback_check
    import kd_tree_pkg::*;
#(
    parameter int NUM_NODES  = 31,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clr,
    input  logic                               wr_valid,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic [STORAGE_WIDTH-1:0]           wr_data,
    input  logic [NUM_NODES*STORAGE_WIDTH-1:0] node_rdata,
    output logic                               err_mismatch,
    output logic [ADDR_WIDTH-1:0]              err_addr
);

    logic                     v1, v2;
    logic [ADDR_WIDTH-1:0]    a1, a2;
    logic [STORAGE_WIDTH-1:0] w1, w2;
    logic [STORAGE_WIDTH-1:0] rd_sel;
    logic [STORAGE_WIDTH-1:0] exp_word;
    logic                     mismatch;

    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NUM_NODES; k++) begin
            if (a2 == ADDR_WIDTH'(k))
                rd_sel = node_rdata[k*STORAGE_WIDTH +: STORAGE_WIDTH];
        end
    end

    assign exp_word = expected_readback(w2);
    assign mismatch = v2 && (rd_sel != exp_word);

    // Stage 1 lines up with the node write, stage 2 with the settled readback.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1           <= 1'b0;
            v2           <= 1'b0;
            a1           <= '0;
            a2           <= '0;
            w1           <= '0;
            w2           <= '0;
            err_mismatch <= 1'b0;
            err_addr     <= '0;
        end else begin
            v1 <= wr_valid;
            a1 <= wr_addr;
            w1 <= wr_data;
            v2 <= v1;
            a2 <= a1;
            w2 <= w1;
            if (clr) begin
                err_mismatch <= 1'b0;
                err_addr     <= '0;
            end else if (mismatch && !err_mismatch) begin
                err_mismatch <= 1'b1;
                err_addr     <= a2;
            end
        end
    end

endmodule

// File: rtl/kd_node_loader.sv
// Write-side controller for the KD-tree internal-node array: streams words
// into nodes in address order and verifies each write by readback.
//
// state | meaning
// IDLE  | waiting for start after reset
// LOAD  | accepting words, one node write per handshake
// DRAIN | two cycles for the final write and its readback check
// DONE  | load complete, errors valid, waiting for start
module kd_node_loader
    import kd_tree_pkg::*;
#(
    parameter int NUM_NODES  = 31,
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_IDX    = kd_tree_pkg::MAX_IDX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    kd_node_loader_if.slave       bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err_mismatch,
    output logic                  err_idx,
    output logic [ADDR_WIDTH-1:0] err_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_NODES - 1);

    state_e                   state;
    logic [ADDR_WIDTH-1:0]    addr;
    logic                     drain_cnt;
    logic                     in_ready_q;
    logic [NUM_NODES-1:0]     node_wen_q;
    logic [STORAGE_WIDTH-1:0] node_wdata_q;
    logic                     hs;
    logic                     start_ok;
    logic                     idx_bad;

    assign hs       = bus.in_valid && in_ready_q;
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign idx_bad  = bus.in_data[IDX_LSB +: IDX_W] > IDX_W'(MAX_IDX);

    assign bus.in_ready   = in_ready_q;
    assign bus.node_wen   = node_wen_q;
    assign bus.node_wdata = node_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            addr         <= '0;
            drain_cnt    <= 1'b0;
            in_ready_q   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_idx      <= 1'b0;
            node_wen_q   <= '0;
            node_wdata_q <= '0;
        end else begin
            node_wen_q <= '0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state      <= ST_LOAD;
                        addr       <= '0;
                        err_idx    <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        node_wen_q   <= NUM_NODES'(1) << addr;
                        node_wdata_q <= bus.in_data;
                        if (idx_bad)
                            err_idx <= 1'b1;
                        if (addr == LAST_ADDR) begin
                            state      <= ST_DRAIN;
                            in_ready_q <= 1'b0;
                            drain_cnt  <= 1'b1;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == 1'b0) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

    kd_node_readback_check #(
        .NUM_NODES  (NUM_NODES),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_check (
        .clk          (clk),
        .rst          (rst),
        .clr          (start_ok),
        .wr_valid     (hs),
        .wr_addr      (addr),
        .wr_data      (bus.in_data),
        .node_rdata   (bus.node_rdata),
        .err_mismatch (err_mismatch),
        .err_addr     (err_addr)
    );

endmodule

// File: tb/tb_kd_node_loader.sv
// Directed bench for kd_node_loader with 31 behavioural node models.
module tb_kd_node_loader;
    import kd_tree_pkg::*;

    localparam int NN = 31;
    localparam int AW = 5;
    localparam int SW = STORAGE_WIDTH;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          err_mismatch;
    logic          err_idx;
    logic [AW-1:0] err_addr;

    int errors = 0;
    int checks = 0;

    logic [SW-1:0] wq [NN];
    logic [SW-1:0] node_mem [NN];
    logic [NN-1:0] stuck;

    kd_node_loader_if #(.NUM_NODES(NN)) bus ();

    kd_node_loader #(
        .NUM_NODES  (NN),
        .ADDR_WIDTH (AW),
        .MAX_IDX    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus.slave),
        .busy         (busy),
        .done         (done),
        .err_mismatch (err_mismatch),
        .err_idx      (err_idx),
        .err_addr     (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Node models store idx and median only; a stuck node stores zero.
    always @(posedge clk) begin
        for (int k = 0; k < NN; k++)
            if (bus.node_wen[k])
                node_mem[k] <= stuck[k] ? '0 : (bus.node_wdata & 22'h3FF807);
    end

    always_comb begin
        bus.node_rdata = '0;
        for (int k = 0; k < NN; k++)
            bus.node_rdata[k*SW +: SW] = node_mem[k];
    end

    task automatic fill_normal();
        for (int k = 0; k < NN; k++)
            wq[k] = SW'((k << 11) | (k % 5));
    endtask

    task automatic run_load(input bit gapped, input int glitch_k, input string tag);
        logic [NN-1:0] exp_wen;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++;
        if (in_check_bad()) begin
            errors++;
            $display("FAIL %s start_state: ready=%b busy=%b done=%b errm=%b erri=%b ea=%0d want 1 1 0 0 0 0",
                     tag, bus.in_ready, busy, done, err_mismatch, err_idx, err_addr);
        end
        for (int k = 0; k < NN; k++) begin
            if (gapped) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
                checks++;
                if (bus.node_wen !== '0) begin
                    errors++;
                    $display("FAIL %s gap_wen k=%0d: got %h want 0", tag, k, bus.node_wen);
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = wq[k];
            if (k == glitch_k) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            exp_wen = NN'(1) << k;
            checks++;
            if (bus.node_wen !== exp_wen || bus.node_wdata !== wq[k]) begin
                errors++;
                $display("FAIL %s write k=%0d: wen=%h wdata=%h want wen=%h wdata=%h",
                         tag, k, bus.node_wen, bus.node_wdata, exp_wen, wq[k]);
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s drain1: done=%b busy=%b ready=%b want 0 1 0", tag, done, busy, bus.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || bus.node_wen !== '0) begin
            errors++;
            $display("FAIL %s drain2: done=%b wen=%h want 0 0", tag, done, bus.node_wen);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done: done=%b busy=%b want 1 0", tag, done, busy);
        end
    endtask

    function automatic bit in_check_bad();
        return bus.in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
               err_mismatch !== 1'b0 || err_idx !== 1'b0 || err_addr !== '0;
    endfunction

    task automatic expect_errs(input string tag, input logic em, input logic ei, input logic [AW-1:0] ea);
        checks++;
        if (err_mismatch !== em || err_idx !== ei || err_addr !== ea) begin
            errors++;
            $display("FAIL %s errs: em=%b ei=%b ea=%0d want em=%b ei=%b ea=%0d",
                     tag, err_mismatch, err_idx, err_addr, em, ei, ea);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; stuck = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.node_wen !== '0 ||
            bus.node_wdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b busy=%b done=%b wen=%h wdata=%h want all 0",
                     bus.in_ready, busy, done, bus.node_wen, bus.node_wdata);
        end
        expect_errs("reset", 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_normal();
        stuck = '0;
        fill_normal();
        run_load(1'b0, -1, "normal");
        expect_errs("normal", 1'b0, 1'b0, 5'd0);
        checks++;
        if (node_mem[30] !== 22'h00F000 || node_mem[9] !== 22'h004804) begin
            errors++;
            $display("FAIL normal_nodes: n30=%h n9=%h want 00f000 004804", node_mem[30], node_mem[9]);
        end
    endtask

    task automatic test_gapped();
        stuck = '0;
        fill_normal();
        run_load(1'b1, -1, "gapped");
        expect_errs("gapped", 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_illegal_idx();
        stuck = '0;
        fill_normal();
        wq[3] = 22'h001806;
        run_load(1'b0, -1, "illegal_idx");
        expect_errs("illegal_idx", 1'b0, 1'b1, 5'd0);
        checks++;
        if (node_mem[3][2:0] !== 3'd6) begin
            errors++;
            $display("FAIL illegal_idx_node: idx=%0d want 6", node_mem[3][2:0]);
        end
    endtask

    task automatic test_readback_fault();
        stuck = '0;
        stuck[7]  = 1'b1;
        stuck[12] = 1'b1;
        fill_normal();
        wq[7] = 22'h3FF805;
        run_load(1'b0, -1, "fault");
        expect_errs("fault", 1'b1, 1'b1, 5'd7);
    endtask

    task automatic test_start_in_done();
        // Run from DONE with errors pending; run_load checks they clear on start.
        stuck = '0;
        fill_normal();
        run_load(1'b0, -1, "restart");
        expect_errs("restart", 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_start_in_load();
        stuck = '0;
        fill_normal();
        run_load(1'b0, 5, "start_in_load");
        expect_errs("start_in_load", 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_mid_reset();
        stuck = '0;
        fill_normal();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = wq[k];
            @(posedge clk); #1;
        end
        rst = 1'b1;
        bus.in_data = wq[10];
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.node_wen !== '0 || busy !== 1'b0 || bus.in_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: wen=%h busy=%b ready=%b done=%b want 0 0 0 0",
                     bus.node_wen, busy, bus.in_ready, done);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: ready=%b busy=%b want 0 0", bus.in_ready, busy);
        end
        run_load(1'b0, -1, "after_reset");
        expect_errs("after_reset", 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal();
        test_gapped();
        test_illegal_idx();
        test_readback_fault();
        test_start_in_done();
        test_start_in_load();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
